exec_stage: RTL
===============

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter RD_W, default 4, destination register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream operation present.
REQ-006 in_ready  output  1  stage accepts the upstream operation this cycle.
REQ-007 in_a, in_b  input  WIDTH  operands.
REQ-008 in_funct  input  2  operation: 00 add, 01 sub, 10 and, 11 asr.
REQ-009 in_cond  input  2  condition: 00 AL, 01 EQ (Z=1), 10 NE (Z=0), 11 LT (N!=V).
REQ-010 in_setf  input  1  operation updates flags.
REQ-011 in_rd  input  RD_W  destination register.
REQ-012 alu_a, alu_b  output  WIDTH  operands driven to the external ALU.
REQ-013 alu_funct  output  2  function driven to the external ALU.
REQ-014 alu_out  input  WIDTH  combinational ALU result for alu_a/alu_b/alu_funct.
REQ-015 out_valid  output  1  result present.
REQ-016 out_ready  input  1  downstream accepts the result.
REQ-017 out_result  output  WIDTH  registered ALU result.
REQ-018 out_rd  output  RD_W  destination register.
REQ-019 out_we  output  1  condition passed; write back.
REQ-020 flags  output  4  architectural {N,Z,C,V}.

Function
REQ-021 SHALL be a two-register pipeline: stage A (operands) and stage B (result), each with its own valid bit.
REQ-022 alu_a/alu_b/alu_funct SHALL be driven directly from the stage A register.
REQ-023 in_ready SHALL = !A_valid | B_advance, where B_advance = !B_valid | out_ready.
REQ-024 A transfer into stage B SHALL occur when A_valid & B_advance; stage B SHALL capture alu_out, rd, and the condition result.
REQ-025 Latency SHALL be 2 cycles: accept at edge k gives out_valid=1 after edge k+1, absent backpressure.
REQ-026 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-027 When out_valid=1 and out_ready=0, out_result, out_rd and out_we SHALL be held stable.
REQ-028 The condition SHALL be evaluated at the A-to-B transfer against the current flags register.
REQ-029 An operation failing its condition SHALL still pass to B with out_we=0 and SHALL NOT update flags.
REQ-030 Flags SHALL update at the A-to-B transfer edge only when in_setf was set and the condition passed.
REQ-031 The next operation in stage A SHALL therefore see the updated flags with no bubble.
REQ-032 N SHALL = result[WIDTH-1]; Z SHALL = (result == 0).
REQ-033 C SHALL be computed locally from the stage A operands with a WIDTH+1-bit sum/difference.
REQ-034 For add, C SHALL be the carry-out; for sub, C SHALL be the no-borrow bit (a >= b unsigned).
REQ-035 V SHALL be signed overflow for add and sub.
REQ-036 For and and asr, C and V SHALL be unchanged.
REQ-037 Simultaneous accept and transfer SHALL load stage A with the new operation while stage B takes the old one.

Reset
REQ-038 Asserting rst_n low SHALL clear A_valid, B_valid, out_valid, out_we and flags to 0 immediately, regardless of clk; out_result and out_rd SHALL reset to 0.
REQ-039 Reset mid-operation SHALL discard in-flight operations without a flag update; in_ready SHALL be 1 in the first cycle after deassertion.

Structure
REQ-040 Package exec_pkg SHALL hold the funct_t and cond_t enums and the flag bit index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
REQ-041 Condition evaluation SHALL be a combinational sub-module named cond_unit (inputs cond, flags; output pass).
REQ-042 The ALU SHALL remain external and SHALL NOT be instantiated inside exec_stage.

Verification
REQ-043 add 0xFFFFFFFF + 0x1, setf=1 -> out_result=0, flags N=0 Z=1 C=1 V=0, two cycles after accept.
REQ-044 sub 0x7FFFFFFF - 0xFFFFFFFF (setf), then LT op in the next cycle -> flags V=1, N=1, C=0, and the LT op has out_we=0.
REQ-045 Back-to-back ops with out_ready held 0 for 3 cycles -> in_ready=0 once both stages are full, output stable, no loss or duplication once released.
REQ-046 EQ op with Z=0 and setf=1 -> out_we=0, flags unchanged.
REQ-047 asr 0x80000000 by 4 with setf -> result 0xF8000000, N=1, Z=0, C and V unchanged.
REQ-048 rst_n low with both stages full -> out_valid=0 and flags=0 immediately; after release the first new op completes normally.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and flag layout for the execute stage.
package exec_pkg;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned N_IDX  = 3;
  localparam int unsigned Z_IDX  = 2;
  localparam int unsigned C_IDX  = 1;
  localparam int unsigned V_IDX  = 0;

  typedef enum logic [1:0] {
    FN_ADD = 2'b00,
    FN_SUB = 2'b01,
    FN_AND = 2'b10,
    FN_ASR = 2'b11
  } funct_t;

  typedef enum logic [1:0] {
    CD_AL = 2'b00,
    CD_EQ = 2'b01,
    CD_NE = 2'b10,
    CD_LT = 2'b11
  } cond_t;

endpackage

// File: rtl/cond_unit.sv
// Combinational condition check of an operation against the architectural flags.
module cond_unit
  import exec_pkg::*;
(
  input  cond_t             cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              pass
);

  always_comb begin
    pass = 1'b0;
    case (cond)
      CD_AL:   pass = 1'b1;
      CD_EQ:   pass = flags[Z_IDX];
      CD_NE:   pass = !flags[Z_IDX];
      CD_LT:   pass = flags[N_IDX] ^ flags[V_IDX];
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Two-register execute stage: stage A feeds an external ALU, stage B holds the
// result; flags are committed at the A-to-B transfer so the next op sees them.
module exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RD_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [1:0]        in_funct,
  input  logic [1:0]        in_cond,
  input  logic              in_setf,
  input  logic [RD_W-1:0]   in_rd,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [1:0]        alu_funct,
  input  logic [WIDTH-1:0]  alu_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  output logic [FLAG_W-1:0] flags
);

  logic              a_valid;
  logic [WIDTH-1:0]  a_a;
  logic [WIDTH-1:0]  a_b;
  funct_t            a_funct;
  cond_t             a_cond;
  logic              a_setf;
  logic [RD_W-1:0]   a_rd;

  logic              b_advance;
  logic              accept;
  logic              a_to_b;
  logic              pass;
  logic              is_sub;
  logic [WIDTH-1:0]  b_op;
  logic [WIDTH:0]    ext_sum;
  logic [FLAG_W-1:0] flags_new;
  logic              unused_sum_bits;

  assign b_advance = !out_valid || out_ready;
  assign in_ready  = !a_valid || b_advance;
  assign accept    = in_valid && in_ready;
  assign a_to_b    = a_valid && b_advance;

  assign alu_a     = a_a;
  assign alu_b     = a_b;
  assign alu_funct = a_funct;

  cond_unit u_cond (
    .cond  (a_cond),
    .flags (flags),
    .pass  (pass)
  );

  // Subtract as a + ~b + 1 so the carry-out is directly the no-borrow bit.
  assign is_sub  = (a_funct == FN_SUB);
  assign b_op    = is_sub ? ~a_b : a_b;
  assign ext_sum = {1'b0, a_a} + {1'b0, b_op} + (WIDTH+1)'(is_sub);
  assign unused_sum_bits = ^ext_sum[WIDTH-2:0];

  always_comb begin
    flags_new        = flags;
    flags_new[N_IDX] = alu_out[WIDTH-1];
    flags_new[Z_IDX] = (alu_out == '0);
    if (a_funct == FN_ADD || a_funct == FN_SUB) begin
      flags_new[C_IDX] = ext_sum[WIDTH];
      flags_new[V_IDX] = (a_a[WIDTH-1] == b_op[WIDTH-1]) &&
                         (ext_sum[WIDTH-1] != a_a[WIDTH-1]);
    end
  end

  // Stage A: operand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_a     <= '0;
      a_b     <= '0;
      a_funct <= FN_ADD;
      a_cond  <= CD_AL;
      a_setf  <= 1'b0;
      a_rd    <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_a     <= in_a;
      a_b     <= in_b;
      a_funct <= funct_t'(in_funct);
      a_cond  <= cond_t'(in_cond);
      a_setf  <= in_setf;
      a_rd    <= in_rd;
    end else if (a_to_b) begin
      a_valid <= 1'b0;
    end
  end

  // Stage B: result register, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_we     <= 1'b0;
    end else if (a_to_b) begin
      out_valid  <= 1'b1;
      out_result <= alu_out;
      out_rd     <= a_rd;
      out_we     <= pass;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (a_to_b && a_setf && pass) begin
      flags <= flags_new;
    end
  end

endmodule
